// File: rtl/signed_star_multiplier.sv
// Pipelined WIDTH x WIDTH two's-complement multiplier with a full 2*WIDTH product and STAGES latency.
// Define SIGNED_STAR_MUL_OVF_EN to add a registered ovf flag aligned with product.
module signed_star_multiplier #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
`ifdef SIGNED_STAR_MUL_OVF_EN
  output logic               ovf,
`endif
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  // Product stages after the multiply; with STAGES == 1 the multiply feeds the only stage.
  localparam int unsigned PS = (STAGES > 1) ? STAGES - 1 : 1;

  function automatic logic [PW-1:0] sext(input logic [WIDTH-1:0] x);
    return {{WIDTH{x[WIDTH-1]}}, x};
  endfunction

  logic [PW-1:0] mul_res;
  logic          mul_vld;

  // Low 2*WIDTH bits of the product of sign-extended operands equal the exact signed product.
  if (STAGES > 1) begin : g_op_stage
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q   <= '0;
        b_q   <= '0;
        vld_q <= 1'b0;
      end else if (ce) begin
        a_q   <= a;
        b_q   <= b;
        vld_q <= in_valid;
      end
    end

    assign mul_res = sext(a_q) * sext(b_q);
    assign mul_vld = vld_q;
  end else begin : g_no_op_stage
    assign mul_res = sext(a) * sext(b);
    assign mul_vld = in_valid;
  end

`ifdef SIGNED_STAR_MUL_OVF_EN
  logic mul_ovf;
  // Overflow when the top WIDTH+1 bits are not a pure sign extension.
  assign mul_ovf = ~((&mul_res[PW-1:WIDTH-1]) | ~(|mul_res[PW-1:WIDTH-1]));
`endif

  for (genvar i = 0; i < PS; i++) begin : g_stage
    logic [PW-1:0] prd_d;
    logic          vld_d;
    logic [PW-1:0] prd_q;
    logic          vld_q;
`ifdef SIGNED_STAR_MUL_OVF_EN
    logic          ovf_d;
    logic          ovf_q;
`endif

    if (i == 0) begin : g_head
      assign prd_d = mul_res;
      assign vld_d = mul_vld;
`ifdef SIGNED_STAR_MUL_OVF_EN
      assign ovf_d = mul_ovf;
`endif
    end else begin : g_tail
      assign prd_d = g_stage[i-1].prd_q;
      assign vld_d = g_stage[i-1].vld_q;
`ifdef SIGNED_STAR_MUL_OVF_EN
      assign ovf_d = g_stage[i-1].ovf_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prd_q <= '0;
        vld_q <= 1'b0;
`ifdef SIGNED_STAR_MUL_OVF_EN
        ovf_q <= 1'b0;
`endif
      end else if (ce) begin
        prd_q <= prd_d;
        vld_q <= vld_d;
`ifdef SIGNED_STAR_MUL_OVF_EN
        ovf_q <= ovf_d;
`endif
      end
    end
  end

  assign product   = g_stage[PS-1].prd_q;
  assign out_valid = g_stage[PS-1].vld_q;
`ifdef SIGNED_STAR_MUL_OVF_EN
  assign ovf       = g_stage[PS-1].ovf_q;
`endif

endmodule

// File: tb/tb_signed_star_multiplier.sv
// Bench for signed_star_multiplier: queue-based reference model checked every cycle plus
// directed vectors with literal expectations.
module tb_signed_star_multiplier;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              ce = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  a = '0;
  logic [WIDTH-1:0]  b = '0;
  logic              out_valid;
  logic [2*WIDTH-1:0] product;
`ifdef SIGNED_STAR_MUL_OVF_EN
  logic              ovf;
`endif

  always #5 clk = ~clk;

  signed_star_multiplier #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
`ifdef SIGNED_STAR_MUL_OVF_EN
    .ovf       (ovf),
`endif
    .product   (product)
  );

  typedef struct {
    bit v;
    int x;
    int y;
  } samp_t;

  samp_t  hist[$];     // captured samples, newest first
  bit     fresh;       // last rising edge advanced the pipeline
  longint log_q[$];    // products seen with out_valid after enabled edges
  bit     ovf_log[$];
  bit     vld_log[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  function automatic longint ref_mul(int x, int y);
    return longint'(x) * longint'(y);
  endfunction

  function automatic bit ref_ovf(longint p);
    return p != longint'(int'(p));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_log(input string nm, input longint exp_q[$]);
    check({nm, " count"}, 64'(log_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) if (i < log_q.size()) check(nm, log_q[i], exp_q[i]);
  endtask

  // Reference: output equals the sample captured STAGES enabled edges ago, else reset value.
  always @(posedge clk or negedge rst_n) begin
    samp_t s;
    if (!rst_n) begin
      hist.delete();
      fresh = 1'b0;
    end else begin
      fresh = ce;
      if (ce) begin
        s.v = in_valid;
        s.x = int'(a);
        s.y = int'(b);
        hist.push_front(s);
        if (hist.size() > STAGES) void'(hist.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    bit     ev;
    bit     from_reset;
    longint ep;
    from_reset = hist.size() < STAGES;
    ev = 1'b0;
    ep = 0;
    if (!from_reset) begin
      ev = hist[STAGES-1].v;
      ep = ref_mul(hist[STAGES-1].x, hist[STAGES-1].y);
    end
    check("out_valid", 64'(out_valid), 64'(ev));
    if (ev || from_reset) check("product", product, ep);
`ifdef SIGNED_STAR_MUL_OVF_EN
    if (ev) check("ovf", 64'(ovf), 64'(ref_ovf(ep)));
    else if (from_reset) check("ovf reset", 64'(ovf), 64'd0);
`endif
    if (fresh) begin
      vld_log.push_back(out_valid);
      if (out_valid) begin
        log_q.push_back(longint'(product));
`ifdef SIGNED_STAR_MUL_OVF_EN
        ovf_log.push_back(ovf);
`endif
      end
    end
  end

  task automatic drive(input bit c, input bit v, input int x, input int y);
    @(posedge clk);
    #1;
    ce       = c;
    in_valid = v;
    a        = x;
    b        = y;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 0, 0);
  endtask

  task automatic clear_logs();
    log_q.delete();
    ovf_log.delete();
    vld_log.delete();
  endtask

  initial begin
    longint exp_q[$];
    int     ones;
    int     first;
    int     corner[6];
    corner = '{0, 1, -1, 32'h7fffffff, 32'h80000000, 2};

    // Reset from power-up
    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset product", product, 64'd0);
    idle(2);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    // Sign combinations, back to back
    clear_logs();
    drive(1, 1, 10, -5);
    drive(1, 1, 15, 20);
    drive(1, 1, -5, -4);
    drive(1, 1, -8, 3);
    drive(1, 1, 0, 7);
    drive(1, 1, 1, -9);
    drive(1, 1, 17, -3);
    drive(1, 1, -10, 9);
    idle(STAGES + 1);
    exp_q = '{-50, 300, 20, -24, 0, -9, -51, -90};
    check_log("sign combos", exp_q);
    first = -1;
    ones  = 0;
    foreach (vld_log[i]) if (vld_log[i]) begin
      if (first < 0) first = i;
      ones++;
    end
    check("combo valid count", 64'(ones), 64'd8);
    if (first >= 0) for (int i = 0; i < 8; i++)
      if (first + i < vld_log.size()) check("combo contiguous", 64'(vld_log[first+i]), 64'd1);

    // Extremes
    clear_logs();
    drive(1, 1, 32'h80000000, 32'h80000000);
    drive(1, 1, 32'h7fffffff, 32'h80000000);
    drive(1, 1, -1, -1);
    idle(STAGES + 1);
    exp_q = '{64'sh4000000000000000, 64'shC000000080000000, 1};
    check_log("extremes", exp_q);
`ifdef SIGNED_STAR_MUL_OVF_EN
    check("extreme ovf count", 64'(ovf_log.size()), 64'd3);
    if (ovf_log.size() == 3) begin
      check("extreme ovf0", 64'(ovf_log[0]), 64'd1);
      check("extreme ovf1", 64'(ovf_log[1]), 64'd1);
      check("extreme ovf2", 64'(ovf_log[2]), 64'd0);
    end
`endif

    // Stall: values driven while ce=0 must never emerge
    clear_logs();
    drive(1, 1, 6, 7);
    drive(0, 1, 1000, 3);
    drive(0, 1, -77, 5);
    drive(0, 1, 123, 456);
    #3;
    check("stall out_valid", 64'(out_valid), 64'd0);
    check("stall fresh", 64'(fresh), 64'd0);
    idle(STAGES + 2);
    exp_q = '{42};
    check_log("stall", exp_q);

    // Bubbles
    clear_logs();
    drive(1, 1, 2, 3);
    drive(1, 0, 9, 9);
    drive(1, 1, -4, 5);
    idle(STAGES + 1);
    exp_q = '{6, -20};
    check_log("bubbles", exp_q);
    first = -1;
    foreach (vld_log[i]) if (vld_log[i] && first < 0) first = i;
    if (first >= 0 && first + 2 < vld_log.size()) begin
      check("bubble gap", 64'(vld_log[first+1]), 64'd0);
      check("bubble second", 64'(vld_log[first+2]), 64'd1);
    end else begin
      check("bubble pattern found", 64'd0, 64'd1);
    end

    // Asynchronous reset with results in flight
    drive(1, 1, 11, 12);
    drive(1, 1, 13, 14);
    drive(1, 1, 15, 16);
    @(posedge clk);
    #2;
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset product", product, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(STAGES + 1);

    // Random traffic with random ce and in_valid
    for (int i = 0; i < 1000; i++) begin
      int x;
      int y;
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : int'($urandom);
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : int'($urandom);
      drive(($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1, x, y);
    end
    idle(STAGES + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/signed_star_multiplier.md
Name: signed_star_multiplier

Overview:
- Pipelined 32x32 two's-complement signed multiplier producing the full 64-bit signed product.
- The ALU datapath instantiates it wherever a registered signed multiply is needed.
- A valid pipeline tracks the operands.
- A clock-enable stalls the whole pipeline in place.

Parameters:
- WIDTH, 32: operand width in bits; product width is 2*WIDTH.
- STAGES, 2: number of register stages from operands to product, minimum 1. Latency equals STAGES cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; 0 freezes every pipeline register
- in_valid  in  1  operands a/b valid this cycle
- a  in  WIDTH  signed multiplicand
- b  in  WIDTH  signed multiplier
- out_valid  out  1  product valid
- product  out  2*WIDTH  signed product a*b

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: rst_n=0 immediately clears out_valid, product and all internal valid/data stages to 0, regardless of clk or ce. Deassertion is taken synchronously; first capture is on the next rising edge with ce=1.
- Arithmetic:
  - Both operands are sign-extended to 2*WIDTH and multiplied.
  - The result is the exact signed product; there is no truncation or rounding.
  - -2^31 * -2^31 = +2^62, which is representable.
  - Any operand times 0 gives 0; a * 1 gives sign-extended a.
- Pipeline timing:
  - On each rising edge with ce=1, stage 0 captures a, b and in_valid.
  - Each later stage advances by one position.
  - out_valid/product reflect the inputs sampled STAGES enabled edges earlier.
  - The pipeline accepts one new operand pair every enabled cycle; throughput is 1/cycle.
- Implementation: the multiply may sit in any stage or be split, e.g. partial products in one stage and a final add in the next, as long as the latency is exact.
- Stall: ce=0 holds all stages, including out_valid and product, unchanged. in_valid and operands presented during ce=0 are ignored.
- Data gating: when in_valid=0 is captured, the data registers of that stage still load. Downstream consumers must qualify product with out_valid. The bench checks product only when out_valid=1.
- Back-to-back operation: consecutive valid inputs produce consecutive valid outputs in order, with no bubbles.
- Reset mid-operation: all in-flight results are discarded and out_valid=0 until new inputs propagate.
- Outputs are driven directly from registers; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SIGNED_STAR_MUL_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered and aligned with product.
  - ovf=1 when the 64-bit product is not representable as a signed WIDTH-bit value, i.e. bits [2*WIDTH-1:WIDTH-1] are not all equal.
  - ovf resets to 0 and stalls with ce.
  - ovf is meaningful only when out_valid=1.
- When undefined: the ovf port and its logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with valid data in flight -> out_valid=0 and product=0 immediately, without waiting for a clock edge.
- Sign combinations, one per cycle with in_valid=1:
  - (10,-5) -> -50
  - (15,20) -> 300
  - (-5,-4) -> 20
  - (-8,3) -> -24
  - (0,7) -> 0
  - (1,-9) -> -9
  - (17,-3) -> -51
  - (-10,9) -> -90
  - Each result appears exactly STAGES cycles after its inputs, in order, with out_valid high for 8 consecutive cycles.
- Extremes:
  - (-2147483648,-2147483648) -> 0x4000000000000000
  - (2147483647,-2147483648) -> 0xC000000080000000
  - (-1,-1) -> 1
  - With SIGNED_STAR_MUL_OVF_EN defined: ovf=1, 1, 0 respectively.
- Stall: issue (6,7), then hold ce=0 for 3 cycles while changing a/b -> product/out_valid frozen. After ce=1 resumes, 42 emerges after the remaining stages, and the values applied during the stall never appear.
- Bubbles: in_valid pattern 1,0,1 with (2,3), (9,9), (-4,5) -> outputs 6, no valid, -20, with out_valid 1,0,1.
- Random: 1000 random signed operand pairs with random ce and in_valid -> every valid output equals the reference 64-bit signed product, in order.
